// File: rtl/out_module_display_if.sv
// rtl/out_module_display_if.sv - strobe/data request and display/status bundle for out_module_display
interface out_module_display_if #(
  parameter int DIGITS = 8
);
  logic                  Out_Signal;
  logic [31:0]           DataIn;
  logic [7*DIGITS-1:0]   Segments;
  logic                  Busy;
  logic                  Done;

  // Requester side: issues strobes with data, observes displays and status
  modport master (
    output Out_Signal,
    output DataIn,
    input  Segments,
    input  Busy,
    input  Done
  );

  // Display peripheral side
  modport slave (
    input  Out_Signal,
    input  DataIn,
    output Segments,
    output Busy,
    output Done
  );
endinterface

// File: rtl/out_module_display.sv
// rtl/out_module_display.sv - 32-bit binary to decimal 7-segment output peripheral with one-deep pending buffer
module out_module_display #(
  parameter int DIGITS      = 8,
  parameter int BLANK_ZEROS = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  out_module_display_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [31:0]          shift_reg;
  logic [39:0]          bcd;
  logic [39:0]          bcd_adj;
  logic [4:0]           count;
  logic [31:0]          pending_data;
  logic                 pending_valid;
  logic [7*DIGITS-1:0]  seg_reg;
  logic [7*DIGITS-1:0]  seg_next;
  logic                 done_reg;
  logic                 overflow;
  logic [3:0]           msd;

  // Active-low 7-segment pattern {g,f,e,d,c,b,a} for one BCD digit
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: 32 double-dabble iterations, then one display-load cycle that may chain straight into the next value
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.Out_Signal) state_next = CONV;
      CONV: if (count == 5'd31) state_next = LOAD;
      LOAD: begin
        if (pending_valid || bus.Out_Signal) state_next = CONV;
        else                                 state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < 10; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  // Display image from the finished BCD: dashes on overflow, leading zeros optionally blanked
  always_comb begin
    seg_next = '1;
    overflow = 1'b0;
    msd      = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (bcd[4*k +: 4] != 4'd0) begin
        if (k >= DIGITS) overflow = 1'b1;
        else             msd      = 4'(k);
      end
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (overflow)
        seg_next[7*k +: 7] = 7'b0111111;
      else if ((BLANK_ZEROS != 0) && (k > int'(msd)))
        seg_next[7*k +: 7] = 7'b1111111;
      else
        seg_next[7*k +: 7] = seg_code(bcd[4*k +: 4]);
    end
  end

  // Conversion datapath, pending buffer (last strobe wins) and display/Done registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg     <= '0;
      bcd           <= '0;
      count         <= '0;
      pending_data  <= '0;
      pending_valid <= 1'b0;
      seg_reg       <= '1;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Out_Signal) begin
            shift_reg <= bus.DataIn;
            bcd       <= '0;
            count     <= '0;
          end
        end
        CONV: begin
          {bcd, shift_reg} <= {bcd_adj[38:0], shift_reg, 1'b0};
          count            <= count + 5'd1;
          if (bus.Out_Signal) begin
            pending_data  <= bus.DataIn;
            pending_valid <= 1'b1;
          end
        end
        LOAD: begin
          seg_reg  <= seg_next;
          done_reg <= 1'b1;
          bcd      <= '0;
          count    <= '0;
          if (pending_valid) begin
            // Buffered value starts now; a same-cycle strobe refills the buffer
            shift_reg     <= pending_data;
            pending_valid <= bus.Out_Signal;
            if (bus.Out_Signal) pending_data <= bus.DataIn;
          end else if (bus.Out_Signal) begin
            shift_reg <= bus.DataIn;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Segments = seg_reg;
  assign bus.Done     = done_reg;
  assign bus.Busy     = (state != IDLE);

endmodule

// File: tb/tb_out_module_display.sv
// tb/tb_out_module_display.sv - directed self-checking bench for out_module_display
module tb_out_module_display;

  localparam int DIGITS = 8;
  localparam logic [55:0] ALL_BLANK = {8{7'b1111111}};
  localparam logic [55:0] ALL_DASH  = {8{7'b0111111}};

  logic clock = 1'b0;
  logic reset = 1'b0;

  out_module_display_if #(.DIGITS(DIGITS)) bus ();

  out_module_display #(.DIGITS(DIGITS), .BLANK_ZEROS(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Expected display from the decimal value itself
  function automatic logic [55:0] render(input longint unsigned v);
    logic [55:0]     r;
    longint unsigned lim;
    longint unsigned t;
    int              d[DIGITS];
    int              top;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    if (v >= lim) return ALL_DASH;
    t   = v;
    top = 0;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = int'(t % 10);
      t    = t / 10;
      if (d[i] != 0) top = i;
    end
    for (int i = 0; i < DIGITS; i++)
      r[7*i +: 7] = (i <= top) ? code(d[i]) : 7'b1111111;
    return r;
  endfunction

  // Transaction-level model: a value is displayed 33 edges after it starts
  bit          m_active = 0;
  int          m_cnt    = 0;
  logic [31:0] m_cur    = '0;
  bit          m_pv     = 0;
  logic [31:0] m_pend   = '0;
  logic [55:0] exp_seg  = ALL_BLANK;
  bit          exp_done = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active = 0; m_cnt = 0; m_pv = 0;
      exp_seg  = ALL_BLANK;
      exp_done = 0;
    end else begin
      exp_done = 0;
      if (!m_active) begin
        if (bus.Out_Signal) begin
          m_active = 1; m_cur = bus.DataIn; m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == 33) begin
          exp_seg  = render(64'(m_cur));
          exp_done = 1;
          if (m_pv) begin
            m_cur = m_pend; m_cnt = 0;
            m_pv  = bus.Out_Signal;
            if (bus.Out_Signal) m_pend = bus.DataIn;
          end else if (bus.Out_Signal) begin
            m_cur = bus.DataIn; m_cnt = 0;
          end else begin
            m_active = 0;
          end
        end else if (bus.Out_Signal) begin
          m_pend = bus.DataIn; m_pv = 1;
        end
      end
    end
  end

  // Every cycle: outputs against the model, sampled mid-cycle
  always @(negedge clock) begin
    check("segments", 64'(bus.Segments), 64'(exp_seg));
    check("busy", 64'(bus.Busy), 64'(m_active));
    check("done", 64'(bus.Done), 64'(exp_done));
  end

  task automatic strobe(input logic [31:0] v);
    @(negedge clock);
    bus.Out_Signal = 1'b1;
    bus.DataIn     = v;
    @(negedge clock);
    bus.Out_Signal = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clock);
      n++;
      if (bus.Done) return;
    end
    n = -1;
  endtask

  task automatic convert(input string name, input logic [31:0] v, input logic [55:0] lit);
    int n;
    strobe(v);
    wait_done(40, n);
    check({name, "_latency"}, 64'(n), 64'd33);
    check({name, "_display"}, 64'(bus.Segments), 64'(lit));
  endtask

  initial begin
    int n;
    int ndone;
    bus.Out_Signal = 1'b0;
    bus.DataIn     = '0;

    // Model pinned against hand-computed displays
    check("model_0", 64'(render(0)), 64'({{7{7'b1111111}}, 7'b1000000}));
    check("model_1234", 64'(render(1234)),
          64'({{4{7'b1111111}}, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}));
    check("model_ovf", 64'(render(100000000)), 64'(ALL_DASH));

    // Asynchronous reset between edges
    #1 reset = 1'b1;
    #1;
    check("rst_seg", 64'(bus.Segments), 64'(ALL_BLANK));
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    check("idle_seg", 64'(bus.Segments), 64'(ALL_BLANK));

    convert("v1234", 32'd1234,
            {{4{7'b1111111}}, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    convert("v0", 32'd0, {{7{7'b1111111}}, 7'b1000000});
    convert("v99999999", 32'd99999999, {8{7'b0010000}});
    convert("v1e8", 32'd100000000, ALL_DASH);
    convert("vmax", 32'hFFFF_FFFF, ALL_DASH);
    convert("v1234b", 32'd1234,
            {{4{7'b1111111}}, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    // Async reset wipes a shown value immediately
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst2_seg", 64'(bus.Segments), 64'(ALL_BLANK));
    check("rst2_busy", 64'(bus.Busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Back-to-back: 5, then 7 at E3, then 9 at E10 (7 overwritten)
    strobe(32'd5);
    ndone = 0;
    for (int i = 1; i <= 70; i++) begin
      bus.Out_Signal = (i == 3 || i == 10);
      bus.DataIn     = (i == 3) ? 32'd7 : ((i == 10) ? 32'd9 : 32'd0);
      @(negedge clock);
      bus.Out_Signal = 1'b0;
      if (bus.Done) begin
        ndone++;
        if (ndone == 1) begin
          check("chain_e5", 64'(i), 64'd33);
          check("chain_seg5", 64'(bus.Segments), 64'({{7{7'b1111111}}, 7'b0010010}));
        end else begin
          check("chain_e9", 64'(i), 64'd66);
          check("chain_seg9", 64'(bus.Segments), 64'({{7{7'b1111111}}, 7'b0010000}));
          check("chain_busy_end", 64'(bus.Busy), 64'd0);
        end
      end
    end
    check("chain_ndone", 64'(ndone), 64'd2);

    // Reset mid-conversion aborts 42; then 8 converts from scratch
    strobe(32'd42);
    repeat (14) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_seg", 64'(bus.Segments), 64'(ALL_BLANK));
    check("abort_busy", 64'(bus.Busy), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    convert("v8", 32'd8, {{7{7'b1111111}}, 7'b0000000});
    repeat (40) @(negedge clock);
    check("final_seg", 64'(bus.Segments), 64'({{7{7'b1111111}}, 7'b0000000}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/out_module_display.md
Name: out_module_display

Overview:
- Output-direction peripheral for the single-cycle MIPS test top; counterpart of the switch input module.
- On an output strobe it captures a 32-bit register value and converts it to decimal with a sequential double-dabble.
- Drives DIGITS active-low 7-segment displays and reports Busy/Done.
- Holds a one-deep pending buffer so back-to-back output instructions are not lost.

Parameters:
- DIGITS, 8: number of displayed decimal digits (supported range 1..10).
- BLANK_ZEROS, 1: 1 blanks leading zero digits (digit 0 always shown); 0 shows all digits.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Out_Signal  input  1  output strobe; one request per cycle it is high.
- DataIn  input  32  unsigned value, sampled with Out_Signal.
- Segments  output  7*DIGITS  digit k at bits [7k+6:7k]; bit order {g,f,e,d,c,b,a}; active-low.
- Busy  output  1  high while state != IDLE.
- Done  output  1  one-cycle pulse after the displays update.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; Segments = all 1s (blank); Done = 0.
  - pending_valid = 0; shift counter, shift register and BCD register = 0.
- States: IDLE, CONV, LOAD. Busy is decoded combinationally from the state register.
- IDLE:
  - Out_Signal = 1 at an edge: load DataIn into shift register, clear BCD (40 bits, 10 digits), clear count, go to CONV.
- CONV, one iteration per edge:
  - Every BCD digit >= 5 gets +3.
  - Then {BCD, shift} shifts left by 1; count increments.
  - After the 32nd iteration, go to LOAD.
- LOAD edge:
  - Segments register updated; Done = 1 for exactly one cycle.
  - Next state, in priority order:
    - pending_valid = 1: start that value in CONV; clear pending.
    - Else Out_Signal = 1: start DataIn in CONV.
    - Else: go to IDLE.
- Latency:
  - Strobe edge E0; iterations E1..E32; update and Done set at E33.
  - Busy is high for 33 cycles per conversion.
- Strobe while Busy (CONV or LOAD):
  - DataIn is stored in pending and pending_valid is set.
  - If pending is already valid, the newer value overwrites it (last-wins).
  - In a LOAD cycle where a pending value is consumed and Out_Signal = 1, DataIn goes into pending.
- Overflow:
  - If any BCD digit at index >= DIGITS is nonzero, every display shows a dash: 0111111.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blank = 1111111.
- Blanking (BLANK_ZEROS = 1):
  - Digits above the most significant nonzero digit are blank.
  - Value 0 shows "0" on digit 0 only.
- Segments hold their value between updates; no change during CONV.
- Reset mid-conversion aborts immediately; no Done pulse; pending is discarded.

Test Plan:
1. Reset asserted asynchronously between edges -> Segments immediately all 1s, Busy 0, Done 0; after release with no strobe, outputs stay unchanged for 100 cycles.
2. DataIn = 1234 with a one-cycle strobe -> Busy high 33 cycles; at E33 digits 3..0 = 1111001, 0100100, 0110000, 0011001 and digits 7..4 blank; Done high exactly one cycle.
3. DataIn = 0 -> digit 0 = 1000000, others blank. Then DataIn = 99999999 -> all 8 digits 0010000.
4. DataIn = 100000000, and separately 0xFFFFFFFF -> all digits 0111111; Done pulses normally.
5. Strobe 5, then 7 at E3, then 9 at E10 -> 7 is overwritten, 9 starts at E33 with no IDLE gap; display 5 at E33, display 9 at E66; Done pulses twice; Busy continuous from E0 to E66.
6. Strobe 42, assert reset at E15 for 2 cycles, release, strobe 8 -> no Done from 42; displays blank until digit 0 = 0000000 at 33 edges after the new strobe.
